// File: rtl/apb_master.sv
// Single-outstanding APB master: IDLE -> SETUP -> ACCESS -> RESP, all outputs decoded from flops.
// Optional ACCESS-phase timeout enabled by defining APB_MASTER_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module apb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [31:0] cmd_addr,
   input  logic [31:0] cmd_wdata,
   input  logic [3:0]  cmd_strb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        tim_psel,
   output logic        tim_penable,
   output logic        tim_pwrite,
   output logic [31:0] tim_paddr,
   output logic [31:0] tim_pwdata,
   output logic [3:0]  tim_pstrb,
   input  logic [31:0] tim_prdata,
   input  logic        tim_pready,
   input  logic        tim_pslverr
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        pwrite_q, pwrite_d;
   logic [31:0] paddr_q, paddr_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic [3:0]  pstrb_q, pstrb_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] tcnt_q, tcnt_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

   // NOTE: every *_d gets a default first so no path through the case can infer a latch.
   always_comb begin
      state_d     = state_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      pstrb_d     = pstrb_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
      tcnt_d      = tcnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_addr[1:0] != 2'b00) begin
                  // Misaligned: answer with an error and never touch the bus.
                  rsp_err_d   = 1'b1;
                  rsp_rdata_d = '0;
                  state_d     = RESP;
               end else begin
                  pwrite_d = cmd_write;
                  paddr_d  = cmd_addr;
                  pwdata_d = cmd_wdata;
                  pstrb_d  = cmd_write ? cmd_strb : 4'h0;
                  state_d  = SETUP;
               end
            end
         end
         SETUP: begin
            state_d = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
            tcnt_d  = '0;
`endif
         end
         ACCESS: begin
            if (tim_pready) begin
               rsp_err_d   = tim_pslverr;
               rsp_rdata_d = pwrite_q ? 32'h0 : tim_prdata;
               state_d     = RESP;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            // tcnt_q counts completed ACCESS cycles, so this is the last allowed one.
            else if (tcnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
               rsp_err_d   = 1'b1;
               rsp_rdata_d = '0;
               state_d     = RESP;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
`endif
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pstrb_q     <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         tcnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         pstrb_q     <= pstrb_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
         tcnt_q      <= tcnt_d;
`endif
      end
   end

   assign cmd_ready   = (state_q == IDLE);
   assign rsp_valid   = (state_q == RESP);
   assign tim_psel    = (state_q == SETUP) || (state_q == ACCESS);
   assign tim_penable = (state_q == ACCESS);
   assign tim_pwrite  = pwrite_q;
   assign tim_paddr   = paddr_q;
   assign tim_pwdata  = pwdata_q;
   assign tim_pstrb   = pstrb_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, default 16, number of ACCESS cycles tolerated without tim_pready; used only when APB_MASTER_TIMEOUT_EN is defined.
REQ-002 SHALL have port: sys_clk  in  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port: sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports, command side:
- cmd_valid  in  1  request present
- cmd_ready  out  1  request accepted this cycle
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  32  byte address
- cmd_wdata  in  32  write data
- cmd_strb  in  4  byte strobes
REQ-005 SHALL have ports, response side:
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  read data
- rsp_err  out  1  transfer error
REQ-006 SHALL have ports, APB side:
- tim_psel, tim_penable, tim_pwrite  out  1 each
- tim_paddr  out  32
- tim_pwdata  out  32
- tim_pstrb  out  4
- tim_prdata  in  32
- tim_pready  in  1
- tim_pslverr  in  1

Function
REQ-007 SHALL implement the FSM IDLE, SETUP, ACCESS, RESP, with every output decoded from registered state and capture registers (no input-to-output combinational path).
REQ-008 SHALL drive cmd_ready=1 only in IDLE; handshake is cmd_valid&&cmd_ready sampled at the clock edge ending cycle N.
REQ-009 On handshake SHALL capture write, addr, wdata and strb; tim_pstrb SHALL equal the captured strb for writes and 4'h0 for reads.
REQ-010 Aligned request (cmd_addr[1:0]==0): SETUP in cycle N+1 (psel=1, penable=0), then ACCESS from N+2 (psel=1, penable=1).
REQ-011 tim_paddr, tim_pwrite, tim_pwdata and tim_pstrb SHALL stay constant from SETUP through the final ACCESS cycle.
REQ-012 SHALL remain in ACCESS while tim_pready=0; on the cycle tim_pready=1, SHALL capture tim_pslverr into rsp_err, and tim_prdata into rsp_rdata for reads (0 for writes), then go to RESP.
REQ-013 RESP SHALL assert rsp_valid for exactly one cycle with psel=penable=0, then return to IDLE; there is no response backpressure.
REQ-014 Zero-wait latency: rsp_valid in N+3, cmd_ready high again in N+4.
REQ-015 Unaligned request (cmd_addr[1:0]!=0) SHALL produce no bus activity: RESP in N+1 with rsp_err=1, rsp_rdata=0.
REQ-016 In IDLE SHALL drive psel=penable=0; tim_paddr, tim_pwrite and tim_pwdata hold their last values.
REQ-017 rsp_rdata and rsp_err SHALL hold their values until the next RESP.

Reset
REQ-018 With sys_rst_n=0, outputs SHALL immediately be: state IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, psel=penable=pwrite=0, paddr=pwdata=0, pstrb=0, timeout count=0.
REQ-019 Reset asserted mid-transfer SHALL abort the transfer with no response pulse; the first cycle after deassertion is IDLE.

Configuration
REQ-020 With macro APB_MASTER_TIMEOUT_EN defined, SHALL:
- clear a counter on entry to ACCESS and increment it each ACCESS cycle with tim_pready=0
- after TIMEOUT_CYCLES ACCESS cycles without pready, go to RESP with rsp_err=1, rsp_rdata=0
- treat pready=1 in the final allowed cycle as normal completion
REQ-021 Without APB_MASTER_TIMEOUT_EN, SHALL contain no counter and SHALL wait in ACCESS indefinitely.

Verification
REQ-022 Write 0x004/0x00000001/strb 0xF, pready tied 1 -> SETUP N+1, ACCESS N+2, rsp_valid N+3 with rsp_err=0, pstrb=0xF during transfer.
REQ-023 Read 0x010, slave holds pready=0 for 3 ACCESS cycles, then pready=1 with prdata 0xDEADBEEF -> ACCESS lasts 4 cycles, rsp_rdata=0xDEADBEEF, pstrb=0, paddr stable throughout.
REQ-024 Write with pslverr=1 on the pready cycle -> rsp_err=1, rsp_rdata=0.
REQ-025 Read 0x002 -> psel never asserts, rsp_valid in N+1 with rsp_err=1.
REQ-026 pready stuck 0, TIMEOUT_CYCLES=16:
- macro defined -> exactly 16 ACCESS cycles, then rsp_err=1
- macro undefined -> psel stays high for 100+ cycles
REQ-027 sys_rst_n pulsed low during ACCESS -> psel=penable=0 immediately, no rsp_valid, cmd_ready=1 in the first cycle after release.
